btn_event_encoder: RTL

//  Conditions the five Basys3 push-buttons into a clean event stream: 2-flop sync, per-button debounce,

---
 rtl/btn_event_encoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/btn_event_encoder.sv
// btn_event_encoder: turns five raw push-buttons into a queue of key-press events.
// Each button is synchronised and debounced. A debounced rising edge marks the
// button as pending. An arbiter pushes the lowest pending code into a small FIFO,
// which the consumer drains with a valid/ready handshake.
// Key codes: C=1 U=2 D=3 L=4 R=5.
// Optional feature macro: AUTOREPEAT_EN. When defined, a held button repeats its event.
module btn_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       ev_ready,
    input  logic       ovf_clr,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    output logic [4:0] btn_level,
    output logic       overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    logic [4:0]    btn_raw;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    stable_q, stable_d, stable_dly_q;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [4:0]    rise;
    logic [4:0]    pending_q, pending_d;
    logic [4:0]    grant;
    logic [2:0]    grant_code;
    logic [4:0]    rep_set;

    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, has_ev, push, pop, discard;

    // Bit order {R,L,D,U,C}, so bit b carries key code b+1.
    assign btn_raw = {btnR, btnL, btnD, btnU, btnC};

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a synced level must differ from stable for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < 5; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync2_q[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                stable_d[b] = sync2_q[b];
                cnt_d[b]    = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
    end

    // Debounce state registers, plus a one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int b = 0; b < 5; b++) cnt_q[b] <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int b = 0; b < 5; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    assign rise = stable_q & ~stable_dly_q;

`ifdef AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX + 1);

    logic [2:0]    sel_code, sel_q;
    logic [TW-1:0] tmr_q, tmr_d;

    // Repeat target: the lowest-code button whose debounced level is high (0 = none).
    always_comb begin
        sel_code = 3'd0;
        for (int b = 4; b >= 0; b--) begin
            if (stable_q[b]) sel_code = 3'(b + 1);
        end
    end

    // Repeat timer: reloads on any change of target, fires after DELAY and then every PERIOD.
    always_comb begin
        tmr_d   = tmr_q;
        rep_set = '0;
        if (sel_code != sel_q) begin
            tmr_d = TW'(REPEAT_DELAY - 1);
        end else if (sel_q != 3'd0) begin
            if (tmr_q == '0) begin
                for (int b = 0; b < 5; b++) begin
                    if (sel_q == 3'(b + 1)) rep_set[b] = 1'b1;
                end
                tmr_d = TW'(REPEAT_PERIOD - 1);
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 3'd0;
            tmr_q <= '0;
        end else begin
            sel_q <= sel_code;
            tmr_q <= tmr_d;
        end
    end
`else
    assign rep_set = '0;
`endif

    // Arbiter: grant the lowest pending code. New rises merge into pending.
    always_comb begin
        grant      = '0;
        grant_code = 3'd0;
        for (int b = 4; b >= 0; b--) begin
            if (pending_q[b]) begin
                grant      = 5'(1 << b);
                grant_code = 3'(b + 1);
            end
        end
        pending_d = (pending_q & ~grant) | rise | rep_set;
    end

    // Pending flags, one per button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign full    = (count_q == DEPTH_C);
    assign has_ev  = |pending_q;
    assign pop     = ev_valid && ev_ready;
    assign push    = has_ev && (!full || pop);
    assign discard = has_ev && full && !pop;

    // FIFO pointer/count and sticky overflow next-state. A discard wins over clear.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        overflow_d = overflow_q;
        if (discard)      overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage. Contents need no reset because ev_code is gated by ev_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= grant_code;
    end

    assign ev_valid  = (count_q != '0);
    assign ev_code   = ev_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign btn_level = stable_q;
    assign overflow  = overflow_q;

endmodule
